uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle of uart_rx: the serial line in, the received byte and status pulses out.
// master is the receiver's view; slave is the view of whoever drives the line and consumes bytes.
interface uart_rx_if;
  logic       i_rx_pin;
  logic [7:0] o_data_byte;
  logic       o_data_valid;
  logic       o_framing_err;
  logic       o_busy;

  modport master (
    input  i_rx_pin,
    output o_data_byte,
    output o_data_valid,
    output o_framing_err,
    output o_busy
  );

  modport slave (
    output i_rx_pin,
    input  o_data_byte,
    input  o_data_valid,
    input  o_framing_err,
    input  o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: samples each bit once at mid-bit and reports each frame as either
// a one-cycle byte-valid pulse or a one-cycle framing-error pulse.
//
// state       | meaning
// S_IDLE      | line idle, waiting for rx_sync low
// S_START     | confirming the start bit at its midpoint
// S_DATA      | sampling 8 data bits, LSB first
// S_STOP      | sampling the stop bit
// S_WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx #(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic             r_sync1, r_sync2;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [7:0]       r_data_byte, w_data_byte_nxt;
  logic             r_data_valid, w_data_valid_nxt;
  logic             r_framing_err, w_framing_err_nxt;

  // The line idles high, so the synchronizer resets to 1 and cannot fake a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.i_rx_pin;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_clk_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data_byte   <= '0;
      r_data_valid  <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_clk_cnt     <= w_clk_cnt_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_data_byte   <= w_data_byte_nxt;
      r_data_valid  <= w_data_valid_nxt;
      r_framing_err <= w_framing_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_clk_cnt_nxt     = r_clk_cnt;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_shift_nxt       = r_shift;
    w_data_byte_nxt   = r_data_byte;
    w_data_valid_nxt  = 1'b0;
    w_framing_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = S_START;
        end
      end
      S_START: begin
        if (r_clk_cnt == CNT_HALF) begin
          if (!r_sync2) begin
            w_clk_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_DATA;
          end else begin
            w_state_nxt   = S_IDLE;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_shift_nxt[r_bit_cnt] = r_sync2;
          w_clk_cnt_nxt          = '0;
          w_bit_cnt_nxt          = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_clk_cnt_nxt = '0;
          if (r_sync2) begin
            w_data_byte_nxt  = r_shift;
            w_data_valid_nxt = 1'b1;
            w_state_nxt      = S_IDLE;
          end else begin
            w_framing_err_nxt = 1'b1;
            w_state_nxt       = S_WAIT_IDLE;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (r_sync2) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.o_data_byte   = r_data_byte;
  assign bus.o_data_valid  = r_data_valid;
  assign bus.o_framing_err = r_framing_err;
  assign bus.o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: expected frame outcomes are queued as
// each frame is driven and compared when the receiver pulses valid or framing error.
module tb_uart_rx;

  localparam int C = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ    (C * 115200),
    .BAUD_RATE   (115200),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_pass  = 0;
  int         n_total = 0;
  int         cyc     = 0;
  int         rise_cyc = 0;
  logic       prev_busy  = 1'b0;
  logic       prev_pulse = 1'b0;
  logic       lat_done   = 1'b0;
  logic [7:0] last_good  = 8'h00;
  exp_t       mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_n) last_good <= 8'h00;
    if (bus.o_data_valid || bus.o_framing_err) begin
      check("pulse_exclusive", {31'd0, bus.o_data_valid & bus.o_framing_err}, 32'd0);
      check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", {31'd0, bus.o_framing_err}, {31'd0, mon_e.is_err});
        if (!mon_e.is_err) begin
          check("data_byte", {24'd0, bus.o_data_byte}, {24'd0, mon_e.data});
          check("busy_after_valid", {31'd0, bus.o_busy}, 32'd0);
          last_good <= mon_e.data;
          if (!lat_done) begin
            lat_done <= 1'b1;
            check("latency_152", {31'd0, (cyc - rise_cyc >= 151) && (cyc - rise_cyc <= 153)}, 32'd1);
          end
        end else begin
          check("byte_held_on_ferr", {24'd0, bus.o_data_byte}, {24'd0, last_good});
          check("busy_after_ferr", {31'd0, bus.o_busy}, 32'd1);
        end
      end
    end
    if (bus.o_busy && !prev_busy) rise_cyc <= cyc;
    prev_busy  <= bus.o_busy;
    prev_pulse <= bus.o_data_valid | bus.o_framing_err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic v);
    bus.i_rx_pin = v;
    tick(C);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    exp_t e;
    e.is_err = ~stop_v;
    e.data   = stop_v ? b : 8'h00;
    sb.push_back(e);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) begin
      bit_out(b[i]);
      if (i == 3) check("busy_mid_frame", {31'd0, bus.o_busy}, 32'd1);
    end
    bit_out(stop_v);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
    check(tag, sb.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte"},  {24'd0, bus.o_data_byte}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.o_data_valid}, 32'd0);
    check({tag, "_ferr"},  {31'd0, bus.o_framing_err}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.o_busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.i_rx_pin = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(5);

    // Clean frame 0xA5; also provides the start-to-valid latency measurement.
    send_frame(8'hA5, 1'b1);
    tick(4);
    drain("drain_a5");

    // Short low glitch must be rejected at the start-bit midpoint.
    bus.i_rx_pin = 1'b0;
    tick(4);
    check("glitch_busy_high", {31'd0, bus.o_busy}, 32'd1);
    bus.i_rx_pin = 1'b1;
    tick(20);
    check("glitch_busy_low", {31'd0, bus.o_busy}, 32'd0);
    check("glitch_byte", {24'd0, bus.o_data_byte}, 32'hA5);
    check("glitch_no_pulse", sb.size(), 32'd0);

    // Bad stop bit followed by a stuck-low line.
    send_frame(8'h3C, 1'b0);
    tick(40);
    check("break_busy_high", {31'd0, bus.o_busy}, 32'd1);
    check("break_byte_kept", {24'd0, bus.o_data_byte}, 32'hA5);
    bus.i_rx_pin = 1'b1;
    tick(5);
    check("break_busy_low", {31'd0, bus.o_busy}, 32'd0);
    drain("drain_break");

    // Back-to-back frames with no idle between stop and next start.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    tick(2);
    drain("drain_b2b");
    check("b2b_last_byte", {24'd0, bus.o_data_byte}, 32'h55);

    // Reset during bit 4 of 0x81 aborts the frame silently.
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b0);
    bus.i_rx_pin = 1'b0;
    tick(8);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    bus.i_rx_pin = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check("post_reset_byte", {24'd0, bus.o_data_byte}, 32'd0);
    check("post_reset_busy", {31'd0, bus.o_busy}, 32'd0);
    send_frame(8'h7E, 1'b1);
    drain("drain_7e");
    check("final_byte", {24'd0, bus.o_data_byte}, 32'h7E);

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
